// File: rtl/seq_gen_if.sv
// Handshake and serial-output bundle for seq_gen.
// start is accepted only on a clock edge where ready is high. The sender gets
// no back-pressure, and a start seen while ready is low is dropped.
interface seq_gen_if #(
    parameter int REPEAT_W = 4
);
    logic                start;
    logic [2:0]          pattern;
    logic [REPEAT_W-1:0] rep;
    logic                ready;
    logic                out;
    logic                out_valid;
    logic                frame;
    logic                done;
    logic [2:0]          dbg_state;

    modport master (
        output start, pattern, rep,
        input  ready, out, out_valid, frame, done, dbg_state
    );

    modport slave (
        input  start, pattern, rep,
        output ready, out, out_valid, frame, done, dbg_state
    );
endinterface

// File: rtl/seq_gen.sv
// Serial 3-bit pattern transmitter. Sends the pattern MSB-first rep+1 times,
// with GAP idle cycles between repetitions.
module seq_gen #(
    parameter int GAP      = 0,
    parameter int REPEAT_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    seq_gen_if.slave  bus
);
    localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B2   = 3'd1,
        B1   = 3'd2,
        B0   = 3'd3,
        GAPW = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          pat_q, pat_d;
    logic [REPEAT_W-1:0] rem_q, rem_d;
    logic [GW-1:0]       gap_q, gap_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= 3'b000;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    rem_d   = bus.rep;
                    state_d = B2;
                end
            end
            B2: state_d = B1;
            B1: state_d = B0;
            B0: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                end else begin
                    // rem_q is non-zero here, so the decrement never wraps
                    rem_d = rem_q - REPEAT_W'(1);
                    if (GAP == 0) begin
                        state_d = B2;
                    end else begin
                        state_d = GAPW;
                        gap_d   = GW'(GAP - 1);
                    end
                end
            end
            GAPW: begin
                if (gap_q == '0) state_d = B2;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready     = 1'b0;
        bus.out       = 1'b0;
        bus.out_valid = 1'b0;
        bus.frame     = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            IDLE: bus.ready = 1'b1;
            B2: begin
                bus.out       = pat_q[2];
                bus.out_valid = 1'b1;
                bus.frame     = 1'b1;
            end
            B1: begin
                bus.out       = pat_q[1];
                bus.out_valid = 1'b1;
            end
            B0: begin
                bus.out       = pat_q[0];
                bus.out_valid = 1'b1;
                bus.done      = (rem_q == '0);
            end
            default: ;
        endcase
    end

    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: one GAP=0 and one GAP=2 instance share the same stimulus.
// A per-cycle expected-output queue is built from each accepted job.
module tb_seq_gen;
  typedef logic [4:0] vec_t; // {ready, out, out_valid, frame, done}
  localparam vec_t IDLE_V = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_s = 1'b0;
  logic [2:0] pattern_s = 3'b000;
  logic [3:0] rep_s = 4'd0;

  int n_checks = 0;
  int n_fail = 0;
  logic armed = 1'b0;
  vec_t q0[$];
  vec_t q2[$];

  always #5 clk = ~clk;

  seq_gen_if #(.REPEAT_W(4)) b0 ();
  seq_gen_if #(.REPEAT_W(4)) b2 ();

  assign b0.start = start_s;
  assign b0.pattern = pattern_s;
  assign b0.rep = rep_s;
  assign b2.start = start_s;
  assign b2.pattern = pattern_s;
  assign b2.rep = rep_s;

  seq_gen #(.GAP(0), .REPEAT_W(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seq_gen #(.GAP(2), .REPEAT_W(4)) u2 (.clk(clk), .rst(rst), .bus(b2));

  // Expected output for every cycle of one job: rep+1 words, gap idles between.
  function automatic void build(input int gap, input logic [2:0] p, input int r, ref vec_t q[$]);
    for (int i = 0; i <= r; i++) begin
      for (int b = 2; b >= 0; b--)
        q.push_back({1'b0, p[b], 1'b1, (b == 2), (i == r && b == 0)});
      if (i < r)
        for (int g = 0; g < gap; g++) q.push_back(5'b00000);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      q0.delete();
      q2.delete();
      armed <= 1'b1;
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (start_s) build(0, pattern_s, int'(rep_s), q0);
      if (q2.size() != 0) void'(q2.pop_front());
      else if (start_s) build(2, pattern_s, int'(rep_s), q2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("model_u0", {27'd0, b0.ready, b0.out, b0.out_valid, b0.frame, b0.done},
          {27'd0, (q0.size() != 0) ? q0[0] : IDLE_V});
      chk("model_u2", {27'd0, b2.ready, b2.out, b2.out_valid, b2.frame, b2.done},
          {27'd0, (q2.size() != 0) ? q2[0] : IDLE_V});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] p, input logic [3:0] r);
    start_s = 1'b1;
    pattern_s = p;
    rep_s = r;
    step();
    start_s = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!(b0.ready && b2.ready) && k < 200) begin
      step();
      k++;
    end
    chk("wait_ready", {31'd0, b0.ready & b2.ready}, 32'd1);
  endtask

  // Shift in n cycles of one instance's outputs, oldest bit ending up highest.
  task automatic capture(input int n, input bit use_gap, output logic [31:0] ov,
                         output logic [31:0] vv, output logic [31:0] fv,
                         output logic [31:0] dv, output logic [31:0] rv);
    ov = '0; vv = '0; fv = '0; dv = '0; rv = '0;
    for (int i = 0; i < n; i++) begin
      ov = {ov[30:0], use_gap ? b2.out : b0.out};
      vv = {vv[30:0], use_gap ? b2.out_valid : b0.out_valid};
      fv = {fv[30:0], use_gap ? b2.frame : b0.frame};
      dv = {dv[30:0], use_gap ? b2.done : b0.done};
      rv = {rv[30:0], use_gap ? b2.ready : b0.ready};
      step();
    end
  endtask

  logic [31:0] ov, vv, fv, dv, rv;
  logic [31:0] ov2, vv2, fv2, dv2, rv2;

  initial begin
    step();
    step();
    rst = 1'b1;
    chk("reset_ready", {31'd0, b0.ready}, 32'd1);
    chk("reset_valid", {31'd0, b0.out_valid}, 32'd0);

    // single word, no repeat
    send(3'b101, 4'd0);
    capture(4, 1'b0, ov, vv, fv, dv, rv);
    chk("t1_out", ov, 32'b1010);
    chk("t1_valid", vv, 32'b1110);
    chk("t1_frame", fv, 32'b1000);
    chk("t1_done", dv, 32'b0010);
    chk("t1_ready", rv, 32'b0001);

    // back-to-back repeats
    wait_ready();
    send(3'b110, 4'd2);
    capture(10, 1'b0, ov, vv, fv, dv, rv);
    chk("t2_out", ov, 32'b1101101100);
    chk("t2_valid", vv, 32'b1111111110);
    chk("t2_frame", fv, 32'b1001001000);
    chk("t2_done", dv, 32'b0000000010);

    // idle gap between repeats
    wait_ready();
    send(3'b111, 4'd1);
    capture(9, 1'b1, ov, vv, fv, dv, rv);
    chk("t3_out", ov, 32'b111001110);
    chk("t3_valid", vv, 32'b111001110);
    chk("t3_done", dv, 32'b000000010);
    chk("t3_ready", rv, 32'b000000001);

    // start while busy is dropped
    wait_ready();
    send(3'b101, 4'd1);
    start_s = 1'b1;
    pattern_s = 3'b000;
    rep_s = 4'd0;
    capture(1, 1'b0, ov, vv, fv, dv, rv);
    start_s = 1'b0;
    capture(8, 1'b0, ov2, vv2, fv2, dv2, rv2);
    chk("t4_out", {ov[0], ov2[7:0]}, 32'b101101000);
    chk("t4_valid", {vv[0], vv2[7:0]}, 32'b111111000);

    // reset mid-word
    wait_ready();
    send(3'b010, 4'd3);
    step();
    chk("t5_b1_valid", {31'd0, b0.out_valid}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_ready", {31'd0, b0.ready}, 32'd1);
    chk("t5_valid", {31'd0, b0.out_valid}, 32'd0);
    chk("t5_done", {31'd0, b0.done}, 32'd0);
    send(3'b100, 4'd0);
    capture(4, 1'b0, ov, vv, fv, dv, rv);
    chk("t5_out", ov, 32'b1000);
    chk("t5_done2", dv, 32'b0010);

    // inputs churn after acceptance
    wait_ready();
    send(3'b011, 4'd1);
    ov = '0;
    vv = '0;
    for (int i = 0; i < 7; i++) begin
      pattern_s = 3'($urandom_range(0, 7));
      rep_s = 4'($urandom_range(0, 15));
      ov = {ov[30:0], b0.out};
      vv = {vv[30:0], b0.out_valid};
      step();
    end
    chk("t6_out", ov, 32'b0110110);
    chk("t6_valid", vv, 32'b1111110);

    // randomized traffic with occasional reset
    wait_ready();
    for (int i = 0; i < 600; i++) begin
      start_s = ($urandom_range(0, 2) == 0);
      pattern_s = 3'($urandom_range(0, 7));
      rep_s = 4'($urandom_range(0, 3));
      rst = ($urandom_range(0, 59) != 0);
      step();
    end
    rst = 1'b1;
    start_s = 1'b0;
    wait_ready();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
